keccak_padder: RTL and testbench

KECCAK_PADDER -- requirements
Module: keccak_padder

---
 rtl/keccak_padder.sv | 147 ++++++++++++++
 tb/tb_keccak_padder.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_padder.sv
// Byte-stream to rate-block padder: Keccak pad10*1 with a domain-separation suffix.
// Define KECCAK_PAD_SHAKE_EN for the SHAKE suffix (0x1F); the default build uses SHA3 (0x06).
//
// state    | meaning
// ---------|--------------------------------------------------------------
// FILL     | accepting message bytes into the rate buffer
// EMIT     | presenting a full or final padded block downstream
// EMIT_PAD | presenting the extra padding-only block (message filled the rate exactly)
module keccak_padder #(
   parameter  int d  = 112,
   parameter  int l  = 6,
   localparam int w  = 2**l,
   localparam int b  = 25*w,
   localparam int c  = 2*d,
   localparam int r  = b-c,
   localparam int RB = r/8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   input  logic         in_last,
   output logic         in_ready,
   output logic [r-1:0] blk_data,
   output logic         blk_valid,
   output logic         blk_last,
   input  logic         blk_ready
);

   localparam int CW = (RB > 1) ? $clog2(RB) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(RB-1);

`ifdef KECCAK_PAD_SHAKE_EN
   localparam logic [7:0] SUFFIX = 8'h1F;
`else
   localparam logic [7:0] SUFFIX = 8'h06;
`endif

   // Padding-only block used when the message ended exactly on a rate boundary.
   localparam logic [r-1:0] PAD_BLK = {8'h80, {(r-16){1'b0}}, SUFFIX};

   typedef enum logic [1:0] {
      FILL     = 2'd0,
      EMIT     = 2'd1,
      EMIT_PAD = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_inc;
   logic          pend_q, pend_d;
   logic          last_q, last_d;
   logic [r-1:0]  buf_q, buf_d;

   assign cnt_inc = cnt_q + CW'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FILL;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         last_q  <= 1'b0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         last_q  <= last_d;
         buf_q   <= buf_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      last_d    = last_q;
      buf_d     = buf_q;
      in_ready  = 1'b0;
      blk_valid = 1'b0;

      case (state_q)
         FILL: begin
            in_ready = 1'b1;
            if (in_valid) begin
               for (int i = 0; i < RB; i++) begin
                  if (CW'(i) == cnt_q) begin
                     buf_d[8*i +: 8] = in_data;
                  end
               end
               if (cnt_q == CNT_MAX) begin
                  // Rate filled; a final byte here defers padding to a separate block.
                  cnt_d   = '0;
                  last_d  = 1'b0;
                  pend_d  = in_last;
                  state_d = EMIT;
               end else if (in_last) begin
                  for (int i = 0; i < RB; i++) begin
                     if (CW'(i) == cnt_inc) begin
                        buf_d[8*i +: 8] = buf_d[8*i +: 8] ^ SUFFIX;
                     end
                  end
                  buf_d[8*(RB-1) +: 8] = buf_d[8*(RB-1) +: 8] ^ 8'h80;
                  cnt_d   = '0;
                  last_d  = 1'b1;
                  state_d = EMIT;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end

         EMIT: begin
            blk_valid = 1'b1;
            if (blk_ready) begin
               if (pend_q) begin
                  buf_d   = PAD_BLK;
                  last_d  = 1'b1;
                  state_d = EMIT_PAD;
               end else begin
                  buf_d   = '0;
                  last_d  = 1'b0;
                  state_d = FILL;
               end
            end
         end

         EMIT_PAD: begin
            blk_valid = 1'b1;
            if (blk_ready) begin
               buf_d   = '0;
               pend_d  = 1'b0;
               last_d  = 1'b0;
               state_d = FILL;
            end
         end

         default: begin
            state_d = FILL;
         end
      endcase
   end

   assign blk_data = buf_q;
   assign blk_last = last_q;

endmodule

// File: tb/tb_keccak_padder.sv
// Self-checking bench for keccak_padder: pad10*1 reference model over byte queues,
// per-cycle compare process, directed boundary cases and a randomized phase.
module tb_keccak_padder;

   localparam int R  = 1376;
   localparam int RB = 172;

`ifdef KECCAK_PAD_SHAKE_EN
   localparam logic [7:0] SUFFIX = 8'h1F;
`else
   localparam logic [7:0] SUFFIX = 8'h06;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [7:0]   in_data = 8'h00;
   logic         in_valid = 1'b0;
   logic         in_last = 1'b0;
   logic         in_ready;
   logic [R-1:0] blk_data;
   logic         blk_valid;
   logic         blk_last;
   logic         blk_ready = 1'b1;

   int checks = 0;
   int errors = 0;
   int rdy_mode = 0;

   logic [R-1:0] exp_q[$];
   logic         exp_last_q[$];
   logic [R-1:0] got_q[$];
   logic         got_last_q[$];

   keccak_padder #(.d(112), .l(6)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .blk_data  (blk_data),
      .blk_valid (blk_valid),
      .blk_last  (blk_last),
      .blk_ready (blk_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #2;
      case (rdy_mode)
         0:       blk_ready = 1'b1;
         1:       blk_ready = ($urandom_range(0, 2) != 0);
         default: blk_ready = 1'b0;
      endcase
   end

   function automatic logic [7:0] byte_at(input logic [R-1:0] v, input int i);
      return v[8*i +: 8];
   endfunction

   function automatic int first_diff(input logic [R-1:0] a, input logic [R-1:0] e);
      for (int i = 0; i < RB; i++) begin
         if (a[8*i +: 8] !== e[8*i +: 8]) return i;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: message || suffix || 0* || 0x80 (suffix and 0x80 XOR when adjacent),
   // total length rounded up to a whole number of rate blocks.
   task automatic push_msg(input logic [7:0] m[$]);
      logic [7:0]   bytes[$];
      logic [R-1:0] blk;
      int n;
      int nb;
      n  = m.size();
      nb = n / RB + 1;
      for (int i = 0; i < nb*RB; i++) bytes.push_back(i < n ? m[i] : 8'h00);
      bytes[n]         = bytes[n] ^ SUFFIX;
      bytes[nb*RB - 1] = bytes[nb*RB - 1] ^ 8'h80;
      for (int k = 0; k < nb; k++) begin
         blk = '0;
         for (int j = 0; j < RB; j++) blk[8*j +: 8] = bytes[k*RB + j];
         exp_q.push_back(blk);
         exp_last_q.push_back(k == nb - 1);
      end
   endtask

   task automatic send_msg(input logic [7:0] m[$], input bit do_last, input bit gaps);
      int  t;
      bit  acc;
      @(posedge clk); #1;
      for (int i = 0; i < m.size(); i++) begin
         if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
         in_valid = 1'b1;
         in_data  = m[i];
         in_last  = do_last && (i == m.size() - 1);
         t   = 0;
         acc = 1'b0;
         while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            t++;
            if (!acc && t > 3000) begin
               checks++;
               errors++;
               $display("FAIL accept_timeout actual=stalled required=accept byte %0d", i);
               in_valid = 1'b0;
               in_last  = 1'b0;
               return;
            end
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_blocks(input int target);
      int t;
      t = 0;
      while (got_q.size() < target && t < 3000) begin
         @(posedge clk); #1;
         t++;
      end
      chk("block_arrival", 32'(got_q.size() >= target), 32'd1);
   endtask

   function automatic int nonzero_between(input logic [R-1:0] v, input int lo, input int hi);
      int n;
      n = 0;
      for (int i = lo; i <= hi; i++) if (v[8*i +: 8] != 8'h00) n++;
      return n;
   endfunction

   // Compare process: every cycle out of reset.
   logic [R-1:0] prev_data;
   logic         prev_last;
   bit           prev_hold = 1'b0;
   logic [R-1:0] cmp_e;
   logic         cmp_el;
   int           cmp_idx;

   always @(negedge clk) begin
      if (!reset) begin
         prev_hold = 1'b0;
      end else begin
         checks++;
         if (in_ready !== !blk_valid) begin
            errors++;
            $display("FAIL ready_excl actual in_ready=%0b blk_valid=%0b required exactly one set", in_ready, blk_valid);
         end
         if (blk_valid && prev_hold) begin
            checks++;
            if (blk_data !== prev_data || blk_last !== prev_last) begin
               errors++;
               cmp_idx = first_diff(blk_data, prev_data);
               $display("FAIL hold_stable byte %0d actual=%0h required=%0h last actual=%0b required=%0b",
                        cmp_idx, byte_at(blk_data, cmp_idx < 0 ? 0 : cmp_idx),
                        byte_at(prev_data, cmp_idx < 0 ? 0 : cmp_idx), blk_last, prev_last);
            end
         end
         if (blk_valid && blk_ready) begin
            got_q.push_back(blk_data);
            got_last_q.push_back(blk_last);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_block actual=block required=none");
            end else begin
               cmp_e  = exp_q.pop_front();
               cmp_el = exp_last_q.pop_front();
               if (blk_data !== cmp_e) begin
                  errors++;
                  cmp_idx = first_diff(blk_data, cmp_e);
                  $display("FAIL blk_data byte %0d actual=%0h required=%0h",
                           cmp_idx, byte_at(blk_data, cmp_idx), byte_at(cmp_e, cmp_idx));
               end
               checks++;
               if (blk_last !== cmp_el) begin
                  errors++;
                  $display("FAIL blk_last actual=%0b required=%0b", blk_last, cmp_el);
               end
            end
         end
         prev_hold = blk_valid && !blk_ready;
         prev_data = blk_data;
         prev_last = blk_last;
      end
   end

   initial begin
      logic [7:0]   msg[$];
      logic [R-1:0] hold;
      int           base;
      int           len;

      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_blk_valid", 32'(blk_valid), 32'd0);
      chk("rst_blk_last", 32'(blk_last), 32'd0);
      chk("rst_blk_data_zero", 32'(blk_data == '0), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;

      // Single byte: suffix right behind it, 0x80 in the final byte, 1-cycle latency.
      msg.delete(); msg.push_back(8'hAB);
      push_msg(msg);
      chk("model_one_byte_b1", 32'(byte_at(exp_q[0], 1)), 32'(SUFFIX));
      base = got_q.size();
      send_msg(msg, 1'b1, 1'b0);
      @(negedge clk);
      chk("latency_blk_valid", 32'(blk_valid), 32'd1);
      chk("latency_in_ready", 32'(in_ready), 32'd0);
      wait_blocks(base + 1);
      chk("one_byte_b0", 32'(byte_at(got_q[base], 0)), 32'hAB);
      chk("one_byte_b1", 32'(byte_at(got_q[base], 1)), 32'(SUFFIX));
      chk("one_byte_b171", 32'(byte_at(got_q[base], 171)), 32'h80);
      chk("one_byte_zeros", 32'(nonzero_between(got_q[base], 2, 170)), 32'd0);
      chk("one_byte_last", 32'(got_last_q[base]), 32'd1);

      // 171 bytes: suffix and 0x80 share the final byte.
      msg.delete(); repeat (171) msg.push_back(8'h11);
      push_msg(msg);
      chk("model_171_b171", 32'(byte_at(exp_q[exp_q.size()-1], 171)), 32'(SUFFIX | 8'h80));
      base = got_q.size();
      send_msg(msg, 1'b1, 1'b0);
      wait_blocks(base + 1);
      chk("b171_b170", 32'(byte_at(got_q[base], 170)), 32'h11);
      chk("b171_b171", 32'(byte_at(got_q[base], 171)), 32'(SUFFIX | 8'h80));
      chk("b171_last", 32'(got_last_q[base]), 32'd1);

      // 172 bytes: full block then a padding-only block.
      msg.delete(); repeat (172) msg.push_back(8'h22);
      push_msg(msg);
      chk("model_172_nblocks", 32'(exp_q.size()), 32'd2);
      base = got_q.size();
      send_msg(msg, 1'b1, 1'b0);
      wait_blocks(base + 2);
      chk("b172_first_b171", 32'(byte_at(got_q[base], 171)), 32'h22);
      chk("b172_first_last", 32'(got_last_q[base]), 32'd0);
      chk("b172_pad_b0", 32'(byte_at(got_q[base+1], 0)), 32'(SUFFIX));
      chk("b172_pad_b171", 32'(byte_at(got_q[base+1], 171)), 32'h80);
      chk("b172_pad_zeros", 32'(nonzero_between(got_q[base+1], 1, 170)), 32'd0);
      chk("b172_pad_last", 32'(got_last_q[base+1]), 32'd1);

      // Backpressure: block held for 5 cycles, input blocked, released by blk_ready.
      rdy_mode = 2;
      msg.delete(); repeat (100) msg.push_back(8'h44);
      push_msg(msg);
      base = got_q.size();
      send_msg(msg, 1'b1, 1'b0);
      @(negedge clk);
      hold = blk_data;
      repeat (5) begin
         @(negedge clk);
         chk("stall_blk_valid", 32'(blk_valid), 32'd1);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_data_same", 32'(blk_data == hold), 32'd1);
      end
      @(posedge clk); #1;
      rdy_mode = 0;
      @(negedge clk);
      chk("release_ready", 32'(blk_ready && blk_valid), 32'd1);
      @(negedge clk);
      chk("release_in_ready", 32'(in_ready), 32'd1);
      wait_blocks(base + 1);

      // Reset mid-message discards everything.
      msg.delete(); repeat (50) msg.push_back(8'($urandom_range(1, 255)));
      send_msg(msg, 1'b0, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_blk_valid", 32'(blk_valid), 32'd0);
      chk("midrst_data_zero", 32'(blk_data == '0), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      msg.delete(); msg.push_back(8'h5A);
      push_msg(msg);
      base = got_q.size();
      send_msg(msg, 1'b1, 1'b0);
      wait_blocks(base + 1);
      chk("after_rst_b0", 32'(byte_at(got_q[base], 0)), 32'h5A);
      chk("after_rst_b1", 32'(byte_at(got_q[base], 1)), 32'(SUFFIX));
      chk("after_rst_b171", 32'(byte_at(got_q[base], 171)), 32'h80);
      chk("after_rst_residue", 32'(nonzero_between(got_q[base], 2, 170)), 32'd0);

      // Zero data byte: suffix visible in byte 1.
      msg.delete(); msg.push_back(8'h00);
      push_msg(msg);
      base = got_q.size();
      send_msg(msg, 1'b1, 1'b0);
      wait_blocks(base + 1);
      chk("zero_byte_b1", 32'(byte_at(got_q[base], 1)), 32'(SUFFIX));
      chk("zero_byte_b171", 32'(byte_at(got_q[base], 171)), 32'h80);

      // Randomized messages with input gaps and random backpressure.
      rdy_mode = 1;
      for (int k = 0; k < 24; k++) begin
         case ($urandom_range(0, 5))
            0:       len = RB - 1;
            1:       len = RB;
            2:       len = RB + 1;
            3:       len = 2*RB;
            default: len = $urandom_range(1, 400);
         endcase
         msg.delete();
         for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
         push_msg(msg);
         send_msg(msg, 1'b1, 1'b1);
      end
      begin
         int t;
         t = 0;
         while (exp_q.size() != 0 && t < 5000) begin
            @(posedge clk); #1;
            t++;
         end
      end
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      rdy_mode = 0;
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
